lcd_scan_ctrl: RTL

//  Single-clock scan sequencer for the 480x272 RGB LCD panel. It replaces the cascaded hcounter/vcounter pair.

---
 rtl/lcd_scan_if.sv | 27 ++
 rtl/lcd_scan_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lcd_scan_if.sv
// rtl/lcd_scan_if.sv - LCD scan controller pin and line-fetch handshake bundle
interface lcd_scan_if;
   logic       enable_i;
   logic       hsync_o;
   logic       vsync_o;
   logic       den_o;
   logic [8:0] col_o;
   logic [8:0] lin_o;
   logic       frame_start_o;
   logic       fetch_req_o;
   logic [8:0] fetch_lin_o;
   logic       fetch_ack_i;
   logic       underrun_o;
   logic       underrun_clr_i;

   modport master (
      input  enable_i, fetch_ack_i, underrun_clr_i,
      output hsync_o, vsync_o, den_o, col_o, lin_o, frame_start_o,
             fetch_req_o, fetch_lin_o, underrun_o
   );

   modport slave (
      output enable_i, fetch_ack_i, underrun_clr_i,
      input  hsync_o, vsync_o, den_o, col_o, lin_o, frame_start_o,
             fetch_req_o, fetch_lin_o, underrun_o
   );
endinterface

// File: rtl/lcd_scan_ctrl.sv
// rtl/lcd_scan_ctrl.sv - LCD raster scan sequencer with per-line fetch request and underrun blanking
module lcd_scan_ctrl #(
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 2,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2
) (
   input  logic        pxclk_i,
   input  logic        rstn_i,
   lcd_scan_if.master  bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] H_S0   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_S1   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [8:0] V_VIS  = 9'(V_ACTIVE);
   localparam logic [8:0] V_S0   = 9'(V_ACTIVE + V_FP);
   localparam logic [8:0] V_S1   = 9'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

   typedef enum logic {IDLE, REQ} state_t;

   state_t     state_q, state_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [8:0] vcnt_q, vcnt_d;
   logic       line_ok_q, line_ok_d;
   logic       underrun_q, underrun_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       den_q, den_d;
   logic [8:0] col_q, col_d;
   logic [8:0] lin_q, lin_d;
   logic       fs_q, fs_d;
   logic       req_q, req_d;
   logic [8:0] flin_q, flin_d;

   logic       wrap;
   logic [8:0] next_line;

   assign wrap      = (hcnt_q == H_LAST);
   assign next_line = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;

   always_comb begin
      state_d    = state_q;
      line_ok_d  = line_ok_q;
      req_d      = req_q;
      flin_d     = flin_q;
      underrun_d = bus.underrun_clr_i ? 1'b0 : underrun_q;
      hcnt_d     = wrap ? 10'd0 : hcnt_q + 10'd1;
      vcnt_d     = vcnt_q;
      if (wrap) begin
         vcnt_d = next_line;
      end

      // Request for line N goes out as soon as line N-1 has finished its visible pixels.
      case (state_q)
         IDLE: begin
            if (hcnt_q == H_VIS && next_line < V_VIS) begin
               state_d   = REQ;
               req_d     = 1'b1;
               flin_d    = next_line;
               line_ok_d = 1'b0;
            end
         end
         REQ: begin
            if (bus.fetch_ack_i) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               line_ok_d = 1'b1;
            end else if (wrap) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               line_ok_d  = 1'b0;
               underrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!bus.enable_i) begin
         hcnt_d     = H_VIS;
         vcnt_d     = V_LAST;
         state_d    = IDLE;
         req_d      = 1'b0;
         flin_d     = 9'd0;
         line_ok_d  = 1'b0;
         underrun_d = bus.underrun_clr_i ? 1'b0 : underrun_q;
      end

      // Outputs are registered from the next counter position so they line up with hcnt_q/vcnt_q.
      hsync_d = !(bus.enable_i && hcnt_d >= H_S0 && hcnt_d < H_S1);
      vsync_d = !(bus.enable_i && vcnt_d >= V_S0 && vcnt_d < V_S1);
      den_d   = bus.enable_i && hcnt_d < H_VIS && vcnt_d < V_VIS && line_ok_d;
      col_d   = den_d ? hcnt_d[8:0] : 9'd0;
      lin_d   = den_d ? vcnt_d : 9'd0;
      fs_d    = bus.enable_i && hcnt_d == 10'd0 && vcnt_d == 9'd0;
   end

   always_ff @(posedge pxclk_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         hcnt_q     <= H_VIS;
         vcnt_q     <= V_LAST;
         line_ok_q  <= 1'b0;
         underrun_q <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         den_q      <= 1'b0;
         col_q      <= 9'd0;
         lin_q      <= 9'd0;
         fs_q       <= 1'b0;
         req_q      <= 1'b0;
         flin_q     <= 9'd0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         line_ok_q  <= line_ok_d;
         underrun_q <= underrun_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         den_q      <= den_d;
         col_q      <= col_d;
         lin_q      <= lin_d;
         fs_q       <= fs_d;
         req_q      <= req_d;
         flin_q     <= flin_d;
      end
   end

   assign bus.hsync_o       = hsync_q;
   assign bus.vsync_o       = vsync_q;
   assign bus.den_o         = den_q;
   assign bus.col_o         = col_q;
   assign bus.lin_o         = lin_q;
   assign bus.frame_start_o = fs_q;
   assign bus.fetch_req_o   = req_q;
   assign bus.fetch_lin_o   = flin_q;
   assign bus.underrun_o    = underrun_q;

endmodule
